tetris_pixel_render: RTL and testbench



---
 rtl/tetris_pixel_render.sv | 190 +++++++++++++++++++
 tb/tb_tetris_pixel_render.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/tetris_pixel_render.sv
`default_nettype none
// ============================================================================
//  Module   : tetris_pixel_render
//  Function : Two-stage pixel colour pipeline for a 10x20 Tetris playfield.
//             Draws cell store contents, a 4 px border, an optional grid
//             and a frame-synchronously latched falling piece.
//  Options  : define GRID_EN to draw 1 px grid lines on empty cells.
//  Revision : 1.0  initial release
// ============================================================================
module tetris_pixel_render #(
  parameter int X_ORG = 240,
  parameter int Y_ORG = 80
) (
  input  logic        CLK_25M,
  input  logic        RST_N,
  input  logic [9:0]  X,
  input  logic [9:0]  Y,
  input  logic        VGA_VS,
  input  logic        wr_en,
  input  logic [3:0]  wr_col,
  input  logic [4:0]  wr_row,
  input  logic [2:0]  wr_data,
  input  logic        piece_req,
  input  logic [15:0] piece_mask,
  input  logic [4:0]  piece_col,
  input  logic [5:0]  piece_row,
  input  logic [2:0]  piece_color,
  output logic        piece_ack,
  output logic [23:0] color_RGB
);

  localparam logic signed [11:0] c_X_ORG  = 12'(X_ORG);
  localparam logic signed [11:0] c_Y_ORG  = 12'(Y_ORG);
  localparam logic [23:0]        c_BORDER = 24'hFFFFFF;
`ifdef GRID_EN
  localparam logic [23:0]        c_GRID   = 24'h404040;
`endif

  // Colour index to RGB lookup
  function automatic logic [23:0] palette(input logic [2:0] idx);
    case (idx)
      3'd1:    palette = 24'h00FFFF;
      3'd2:    palette = 24'hFFFF00;
      3'd3:    palette = 24'h800080;
      3'd4:    palette = 24'h00FF00;
      3'd5:    palette = 24'hFF0000;
      3'd6:    palette = 24'h0000FF;
      3'd7:    palette = 24'hFF8000;
      default: palette = 24'h000000;
    endcase
  endfunction

  // ---------------- stage 1 geometry (combinational) ----------------
  logic signed [11:0] w_dx, w_dy;
  logic               w_in_field, w_in_ring;

  assign w_dx = $signed({2'b00, X}) - c_X_ORG;
  assign w_dy = $signed({2'b00, Y}) - c_Y_ORG;

  assign w_in_field = (w_dx >= 12'sd0) && (w_dx < 12'sd160) &&
                      (w_dy >= 12'sd0) && (w_dy < 12'sd320);
  assign w_in_ring  = (w_dx >= -12'sd4) && (w_dx < 12'sd164) &&
                      (w_dy >= -12'sd4) && (w_dy < 12'sd324) && !w_in_field;

  logic       r_in_field, r_in_ring;
  logic [3:0] r_col;
  logic [4:0] r_row;
`ifdef GRID_EN
  logic [3:0] r_offx, r_offy;
`endif

  // Stage 1 register: flags plus cell coordinates (zeroed outside the field
  // so the stage 2 cell index always stays within the store)
  always_ff @(posedge CLK_25M) begin
    if (!RST_N) begin
      r_in_field <= 1'b0;
      r_in_ring  <= 1'b0;
      r_col      <= '0;
      r_row      <= '0;
`ifdef GRID_EN
      r_offx     <= '0;
      r_offy     <= '0;
`endif
    end else begin
      r_in_field <= w_in_field;
      r_in_ring  <= w_in_ring;
      r_col      <= w_in_field ? w_dx[7:4] : 4'd0;
      r_row      <= w_in_field ? w_dy[8:4] : 5'd0;
`ifdef GRID_EN
      r_offx     <= w_dx[3:0];
      r_offy     <= w_dy[3:0];
`endif
    end
  end

  // ---------------- cell store ----------------
  logic [2:0] r_cells [0:199];
  logic       w_wr_ok;
  logic [7:0] w_wr_idx;

  assign w_wr_ok  = wr_en && (wr_col <= 4'd9) && (wr_row <= 5'd19);
  assign w_wr_idx = ({3'b000, wr_row} * 8'd10) + {4'b0000, wr_col};

  // Cell store write port; reset clears the whole board
  always_ff @(posedge CLK_25M) begin
    if (!RST_N) begin
      for (int i = 0; i < 200; i++) r_cells[i] <= 3'd0;
    end else if (w_wr_ok) begin
      r_cells[w_wr_idx] <= wr_data;
    end
  end

  // ---------------- piece shadow registers ----------------
  logic        r_vs_d, r_ack;
  logic [15:0] r_pmask;
  logic [4:0]  r_pcol;
  logic [5:0]  r_prow;
  logic [2:0]  r_pcolor;
  logic        w_frame_start;

  assign w_frame_start = r_vs_d && !VGA_VS;

  // Latch the piece at the VS falling edge when a request is pending
  always_ff @(posedge CLK_25M) begin
    if (!RST_N) begin
      r_vs_d   <= 1'b1;
      r_ack    <= 1'b0;
      r_pmask  <= '0;
      r_pcol   <= '0;
      r_prow   <= '0;
      r_pcolor <= '0;
    end else begin
      r_vs_d <= VGA_VS;
      r_ack  <= w_frame_start && piece_req;
      if (w_frame_start && piece_req) begin
        r_pmask  <= piece_mask;
        r_pcol   <= piece_col;
        r_prow   <= piece_row;
        r_pcolor <= piece_color;
      end
    end
  end

  assign piece_ack = r_ack;

  // ---------------- stage 2: lookup, hit test, priority ----------------
  logic [7:0]        w_idx;
  logic [2:0]        w_cell;
  logic signed [6:0] w_dc, w_dr;
  logic              w_hit;
  logic [23:0]       w_rgb;

  assign w_idx  = ({3'b000, r_row} * 8'd10) + {4'b0000, r_col};
  assign w_cell = r_cells[w_idx];
  assign w_dc   = $signed({3'b000, r_col}) - $signed({{2{r_pcol[4]}}, r_pcol});
  assign w_dr   = $signed({2'b00, r_row})  - $signed({r_prow[5], r_prow});
  assign w_hit  = (w_dc[6:2] == 5'd0) && (w_dr[6:2] == 5'd0) &&
                  r_pmask[{w_dr[1:0], w_dc[1:0]}];

  // Colour priority: piece, stored cell, grid, black; border outside field
  always_comb begin
    w_rgb = 24'h000000;
    if (r_in_field) begin
      if (w_hit && (r_pcolor != 3'd0)) begin
        w_rgb = palette(r_pcolor);
      end else if (w_cell != 3'd0) begin
        w_rgb = palette(w_cell);
      end
`ifdef GRID_EN
      else if ((r_offx == 4'd0) || (r_offy == 4'd0)) begin
        w_rgb = c_GRID;
      end
`endif
    end else if (r_in_ring) begin
      w_rgb = c_BORDER;
    end
  end

  logic [23:0] r_rgb;

  // Output colour register
  always_ff @(posedge CLK_25M) begin
    if (!RST_N) r_rgb <= '0;
    else        r_rgb <= w_rgb;
  end

  assign color_RGB = r_rgb;

endmodule
`default_nettype wire

// File: tb/tb_tetris_pixel_render.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tetris_pixel_render
//  Function : Directed self-checking bench for tetris_pixel_render.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tetris_pixel_render;

  logic        CLK_25M = 1'b0;
  logic        RST_N = 1'b0;
  logic [9:0]  X = '0, Y = '0;
  logic        VGA_VS = 1'b1;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_col = '0;
  logic [4:0]  wr_row = '0;
  logic [2:0]  wr_data = '0;
  logic        piece_req = 1'b0;
  logic [15:0] piece_mask = '0;
  logic [4:0]  piece_col = '0;
  logic [5:0]  piece_row = '0;
  logic [2:0]  piece_color = '0;
  logic        piece_ack;
  logic [23:0] color_RGB;

  int checks = 0;
  int failures = 0;

`ifdef GRID_EN
  localparam logic [23:0] c_GRID_EXP = 24'h404040;
`else
  localparam logic [23:0] c_GRID_EXP = 24'h000000;
`endif

  tetris_pixel_render #(.X_ORG(240), .Y_ORG(80)) dut (
    .CLK_25M(CLK_25M), .RST_N(RST_N), .X(X), .Y(Y), .VGA_VS(VGA_VS),
    .wr_en(wr_en), .wr_col(wr_col), .wr_row(wr_row), .wr_data(wr_data),
    .piece_req(piece_req), .piece_mask(piece_mask), .piece_col(piece_col),
    .piece_row(piece_row), .piece_color(piece_color),
    .piece_ack(piece_ack), .color_RGB(color_RGB)
  );

  always #20 CLK_25M = ~CLK_25M;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK_25M);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic px(input string tag, input int xx, input int yy, input logic [23:0] exp);
    X = 10'(xx);
    Y = 10'(yy);
    step(2);
    chk(tag, color_RGB, exp);
  endtask

  task automatic wr(input int c, input int r, input int d);
    wr_en = 1'b1; wr_col = 4'(c); wr_row = 5'(r); wr_data = 3'(d);
    step(1);
    wr_en = 1'b0;
  endtask

  task automatic vs_edge(input string tag, input logic exp_ack);
    VGA_VS = 1'b0;
    step(1);
    chk({tag, "_ack"}, {23'd0, piece_ack}, {23'd0, exp_ack});
    step(1);
    chk({tag, "_ack_end"}, {23'd0, piece_ack}, 24'd0);
    piece_req = 1'b0;
    VGA_VS = 1'b1;
    step(1);
  endtask

  initial begin
    // reset state
    step(3);
    chk("rst_rgb", color_RGB, 24'h0);
    chk("rst_ack", {23'd0, piece_ack}, 24'd0);
    RST_N = 1'b1;

    px("empty_mid",   300, 100, 24'h000000);
    px("grid_x0",     304, 100, c_GRID_EXP);

    // cell store
    wr(0, 0, 5);
    px("cell00_red",  240, 80, 24'hFF0000);
    wr(10, 0, 3);
    px("oob_keep00",  245, 85, 24'hFF0000);
    px("oob_alias10", 245, 101, 24'h000000);

    // border
    px("border_left", 238, 200, 24'hFFFFFF);
    px("outside_l",   235, 200, 24'h000000);
    px("border_right",400, 399, 24'hFFFFFF);
    px("border_corner",236, 76, 24'hFFFFFF);
    px("outside_r",   404, 200, 24'h000000);

    // stored index 2 at (4,0)
    wr(4, 0, 2);
    px("cell40_yel",  309, 85, 24'hFFFF00);

    // piece handshake
    piece_req = 1'b1; piece_mask = 16'h0033; piece_col = 5'd4;
    piece_row = 6'd0; piece_color = 3'd1;
    step(1);
    chk("pre_edge_ack", {23'd0, piece_ack}, 24'd0);
    vs_edge("latch1", 1'b1);
    px("piece_40",    309, 85, 24'h00FFFF);
    px("piece_50",    325, 85, 24'h00FFFF);
    px("piece_41",    309, 101, 24'h00FFFF);
    px("piece_51",    325, 101, 24'h00FFFF);
    px("nopiece_60",  341, 85, 24'h000000);
    px("nopiece_42",  309, 117, 24'h000000);

    // no request: shadow retained, no ack
    piece_mask = 16'h0000; piece_color = 3'd0;
    vs_edge("noreq", 1'b0);
    px("keep_40",     309, 85, 24'h00FFFF);

    // clipping row -1
    piece_req = 1'b1; piece_mask = 16'h00F0; piece_col = 5'd4;
    piece_row = 6'h3F; piece_color = 3'd6;
    vs_edge("latch2", 1'b1);
    px("clip1_40",    309, 85, 24'h0000FF);
    px("clip1_70",    357, 85, 24'h0000FF);
    px("clip1_80",    373, 85, 24'h000000);
    px("clip1_41",    309, 101, 24'h000000);

    // clipping row -2: nothing drawn
    piece_req = 1'b1; piece_row = 6'h3E;
    vs_edge("latch3", 1'b1);
    px("clip2_40",    309, 85, 24'hFFFF00);
    px("clip2_50",    325, 85, 24'h000000);

    // reset mid-line with cells filled
    X = 10'd245; Y = 10'd85;
    step(2);
    chk("pre_rst_cell", color_RGB, 24'hFF0000);
    RST_N = 1'b0;
    step(1);
    chk("midrst_rgb", color_RGB, 24'h0);
    RST_N = 1'b1;
    px("cleared_00",  245, 85, 24'h000000);
    px("cleared_40",  309, 85, 24'h000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
